// File: rtl/br_resolve_queue.sv
// br_resolve_queue: in-flight branch FIFO that pairs BTB predictions with execute outcomes
module br_resolve_queue #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     EN,
   input  logic                     pred_valid,
   input  logic [W-1:0]             pred_PC,
   input  logic                     pred_hit,
   input  logic [W-1:0]             pred_TARGET,
   output logic                     pred_ready,
   input  logic                     ex_valid,
   input  logic                     ex_taken,
   input  logic [W-1:0]             ex_TARGET,
   output logic                     resolve,
   output logic                     pr_br_taken,
   output logic                     pr_hit,
   output logic [W-1:0]             pr_TARGET,
   output logic [W-1:0]             PC_addr,
   output logic                     mispredict,
   output logic [W-1:0]             redirect_PC,
   output logic                     underflow,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_pc  [DEPTH];
   logic [W-1:0]  mem_tgt [DEPTH];
   logic          mem_hit [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          enq, deq, mis, empty;
   logic [W-1:0]  h_pc, h_tgt;
   logic          h_hit;
   assign empty      = count == '0;
   assign pred_ready = count < (AW+1)'(DEPTH);
   assign enq        = EN && pred_valid && pred_ready;
   assign deq        = EN && ex_valid && !empty;
   assign h_pc       = mem_pc[rd_ptr];
   assign h_tgt      = mem_tgt[rd_ptr];
   assign h_hit      = mem_hit[rd_ptr];
   assign mis        = deq && (h_hit != ex_taken || (h_hit && ex_taken && h_tgt != ex_TARGET));
   // entry storage; a wrong-path enqueue beside a flush is never written
   always_ff @(posedge clk) begin
      if (enq && !mis) begin
         mem_pc[wr_ptr]  <= pred_PC;
         mem_hit[wr_ptr] <= pred_hit;
         mem_tgt[wr_ptr] <= pred_TARGET;
      end
   end
   // pointers, occupancy and the registered BTB-update / flush outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         resolve     <= 1'b0;
         mispredict  <= 1'b0;
         underflow   <= 1'b0;
         pr_br_taken <= 1'b0;
         pr_hit      <= 1'b0;
         pr_TARGET   <= '0;
         PC_addr     <= '0;
         redirect_PC <= '0;
      end else if (!EN) begin
         resolve     <= 1'b0;
         mispredict  <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         resolve     <= deq;
         mispredict  <= mis;
         underflow   <= ex_valid && empty;
         if (deq) begin
            pr_br_taken <= ex_taken;
            pr_hit      <= h_hit;
            pr_TARGET   <= ex_TARGET;
            PC_addr     <= h_pc;
            redirect_PC <= ex_taken ? ex_TARGET : h_pc + W'(4);
         end
         if (mis) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(enq);
            rd_ptr <= rd_ptr + AW'(deq);
            count  <= count + (AW+1)'(enq) - (AW+1)'(deq);
         end
      end
   end
endmodule

// File: tb/tb_br_resolve_queue.sv
// tb_br_resolve_queue: scoreboard bench for br_resolve_queue
module tb_br_resolve_queue;
   localparam int W = 32;
   localparam int DEPTH = 4;
   logic clk = 0, rst, EN, pred_valid, pred_hit, pred_ready, ex_valid, ex_taken;
   logic [W-1:0] pred_PC, pred_TARGET, ex_TARGET;
   logic resolve, pr_br_taken, pr_hit, mispredict, underflow;
   logic [W-1:0] pr_TARGET, PC_addr, redirect_PC;
   logic [2:0] count;
   int total = 0, bad = 0;
   typedef struct {logic [W-1:0] pc; logic hit; logic [W-1:0] tgt;} ent_t;
   typedef struct {logic taken; logic hit; logic mis; logic [W-1:0] tgt; logic [W-1:0] pc; logic [W-1:0] redir;} exp_t;
   ent_t mq[$];
   exp_t eq[$];
   logic m_res, m_mis, m_und;
   logic [W-1:0] m_pcaddr;

   always #5 clk = ~clk;

   br_resolve_queue #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .EN(EN),
      .pred_valid(pred_valid), .pred_PC(pred_PC), .pred_hit(pred_hit), .pred_TARGET(pred_TARGET),
      .pred_ready(pred_ready),
      .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_TARGET(ex_TARGET),
      .resolve(resolve), .pr_br_taken(pr_br_taken), .pr_hit(pr_hit), .pr_TARGET(pr_TARGET),
      .PC_addr(PC_addr), .mispredict(mispredict), .redirect_PC(redirect_PC),
      .underflow(underflow), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic e,
                       input logic pv, input logic [W-1:0] pc, input logic h, input logic [W-1:0] pt,
                       input logic xv, input logic xt, input logic [W-1:0] xg);
      ent_t hd;
      exp_t x;
      logic enq, mis;
      rst = r; EN = e; pred_valid = pv; pred_PC = pc; pred_hit = h; pred_TARGET = pt;
      ex_valid = xv; ex_taken = xt; ex_TARGET = xg;
      @(posedge clk);
      m_res = 0; m_mis = 0; m_und = 0;
      if (r) begin
         mq.delete();
         eq.delete();
         m_pcaddr = '0;
      end else if (e) begin
         enq = pv && mq.size() < DEPTH;
         m_und = xv && mq.size() == 0;
         if (xv && mq.size() > 0) begin
            hd = mq.pop_front();
            mis = (hd.hit != xt) || (hd.hit && xt && hd.tgt != xg);
            m_res = 1; m_mis = mis; m_pcaddr = hd.pc;
            eq.push_back('{taken: xt, hit: hd.hit, mis: mis, tgt: xg, pc: hd.pc,
                           redir: xt ? xg : hd.pc + 32'd4});
            if (mis) begin
               mq.delete();
               enq = 0;
            end
         end
         if (enq) mq.push_back('{pc: pc, hit: h, tgt: pt});
      end
      #1;
      chk("count", 64'(count), 64'(mq.size()));
      chk("pred_ready", 64'(pred_ready), 64'(mq.size() < DEPTH));
      chk("resolve", 64'(resolve), 64'(m_res));
      chk("mispredict", 64'(mispredict), 64'(m_mis));
      chk("underflow", 64'(underflow), 64'(m_und));
      chk("PC_addr", 64'(PC_addr), 64'(m_pcaddr));
      if (r) begin
         chk("rst_pr_TARGET", 64'(pr_TARGET), 64'd0);
         chk("rst_redirect", 64'(redirect_PC), 64'd0);
         chk("rst_pr_hit", 64'(pr_hit), 64'd0);
         chk("rst_pr_taken", 64'(pr_br_taken), 64'd0);
      end
      if (resolve === 1'b1) begin
         if (eq.size() == 0) chk("resolve_unexpected", 64'd1, 64'd0);
         else begin
            x = eq.pop_front();
            chk("pr_br_taken", 64'(pr_br_taken), 64'(x.taken));
            chk("pr_hit", 64'(pr_hit), 64'(x.hit));
            chk("pr_TARGET", 64'(pr_TARGET), 64'(x.tgt));
            if (x.mis) chk("redirect_PC", 64'(redirect_PC), 64'(x.redir));
         end
      end
   endtask

   task automatic idle();
      step(0, 1, 0, '0, 0, '0, 0, 0, '0);
   endtask

   task automatic push(input logic [W-1:0] pc, input logic h, input logic [W-1:0] t);
      step(0, 1, 1, pc, h, t, 0, 0, '0);
   endtask

   task automatic pop(input logic xt, input logic [W-1:0] xg);
      step(0, 1, 0, '0, 0, '0, 1, xt, xg);
   endtask

   initial begin
      step(1, 0, 0, '0, 0, '0, 0, 0, '0);
      step(1, 1, 1, 32'h999, 1, 32'h1, 1, 1, 32'h2);
      // fill and drop fifth
      push(32'h120, 0, 32'h0);
      push(32'h220, 0, 32'h0);
      push(32'h320, 0, 32'h0);
      push(32'h420, 0, 32'h0);
      push(32'h520, 0, 32'h0);
      chk("full_count", 64'(count), 64'd4);
      // drain with correct not-taken resolutions
      for (int i = 0; i < 4; i++) pop(0, 32'h0);
      idle();
      // correct taken prediction
      push(32'h120, 1, 32'hAAAAAAAA);
      pop(1, 32'hAAAAAAAA);
      chk("ok_pc", 64'(PC_addr), 64'h120);
      idle();
      // cold miss
      push(32'h130, 0, 32'h0);
      pop(1, 32'hBBBBBBBB);
      chk("cold_redirect", 64'(redirect_PC), 64'hBBBBBBBB);
      idle();
      // flush with wrong-path enqueue
      push(32'h220, 1, 32'h7000);
      push(32'h320, 0, 32'h0);
      push(32'h420, 0, 32'h0);
      step(0, 1, 1, 32'h520, 0, '0, 1, 0, 32'h0);
      chk("flush_redirect", 64'(redirect_PC), 64'h224);
      idle();
      // wrap with simultaneous enqueue/dequeue, then wrong target
      push(32'h1000, 1, 32'h5000);
      for (int i = 1; i <= 10; i++)
         step(0, 1, 1, 32'h1000 + 32'(i) * 32'h10, 1, (i == 10) ? 32'hCCCCCCCC : 32'h5000 + 32'(i),
              1, 1, 32'h5000 + 32'(i - 1));
      pop(1, 32'hDDDDDDDD);
      chk("wrap_pc", 64'(PC_addr), 64'h10A0);
      idle();
      // EN low holds everything
      push(32'h600, 1, 32'h6600);
      step(0, 0, 1, 32'h700, 1, 32'h7700, 1, 1, 32'h6600);
      pop(1, 32'h6600);
      idle();
      // underflow
      pop(1, 32'h1234);
      idle();
      // reset with entries queued
      push(32'h800, 0, 32'h0);
      push(32'h900, 0, 32'h0);
      step(1, 1, 1, 32'hA00, 0, '0, 1, 1, 32'h55);
      idle();
      pop(0, 32'h0);
      chk("scoreboard_empty", 64'(eq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
